// File: rtl/spi_ram_ctrl_if.sv
// Handshake bundle between the SPI slave shifter and spi_ram_ctrl.
// din/rx_valid flow into the RAM; dout/tx_valid/err flow back out.
interface spi_ram_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH+1:0] din;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  err;

  modport master (
    output din, rx_valid,
    input  dout, tx_valid, err
  );

  modport slave (
    input  din, rx_valid,
    output dout, tx_valid, err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoded single-port RAM behind the SPI slave front end.
// Define SPI_RAM_AUTOINC_EN for pointer auto-increment on data commands.
module spi_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_ram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } cmd_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] pld;
  logic [ADDR_SIZE-1:0]  pld_addr;

  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_q, tx_d;
  logic                  err_q, err_d;
  logic                  we;

  assign cmd      = cmd_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
  assign pld      = bus.din[DATA_WIDTH-1:0];
  assign pld_addr = pld[ADDR_SIZE-1:0];

  function automatic logic oob(
    input logic [ADDR_SIZE-1:0] a
  );
    return 32'(a) >= 32'(MEM_DEPTH);
  endfunction

`ifdef SPI_RAM_AUTOINC_EN
  // Wrap on >= so an out-of-range pointer also returns to 0.
  function automatic logic [ADDR_SIZE-1:0] nxt(
    input logic [ADDR_SIZE-1:0] a
  );
    if (32'(a) >= 32'(MEM_DEPTH - 1))
      return '0;
    return a + 1'b1;
  endfunction
`endif

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    dout_d    = dout_q;
    tx_d      = 1'b0;
    err_d     = 1'b0;
    we        = 1'b0;
    if (bus.rx_valid) begin
      unique case (1'b1)
        cmd == CMD_WADDR: wr_addr_d = pld_addr;
        cmd == CMD_WDATA: begin
          we    = !oob(wr_addr_q);
          err_d = oob(wr_addr_q);
`ifdef SPI_RAM_AUTOINC_EN
          wr_addr_d = nxt(wr_addr_q);
`endif
        end
        cmd == CMD_RADDR: rd_addr_d = pld_addr;
        cmd == CMD_RDATA: begin
          tx_d   = 1'b1;
          err_d  = oob(rd_addr_q);
          dout_d = oob(rd_addr_q) ? '0 : mem[rd_addr_q];
`ifdef SPI_RAM_AUTOINC_EN
          rd_addr_d = nxt(rd_addr_q);
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      dout_q    <= '0;
      tx_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      dout_q    <= dout_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we)
      mem[wr_addr_q] <= pld;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: depth-256 (A) and depth-200 (B).
// Expectations follow SPI_RAM_AUTOINC_EN when it is defined.
module tb_spi_ram_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl_if #(.DATA_WIDTH(8)) ia ();
  spi_ram_ctrl_if #(.DATA_WIDTH(8)) ib ();

  spi_ram_ctrl #(
    .DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  spi_ram_ctrl #(
    .DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(200)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input bit         sel,
    input logic [1:0] c,
    input logic [7:0] p
  );
    if (!sel) begin
      ia.din = {c, p}; ia.rx_valid = 1'b1;
      ib.rx_valid = 1'b0;
    end else begin
      ib.din = {c, p}; ib.rx_valid = 1'b1;
      ia.rx_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ia.din = {2'b11, 8'h00}; ia.rx_valid = 1'b0;
    ib.din = {2'b01, 8'h99}; ib.rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_a(
    input string      tag,
    input logic [7:0] d,
    input logic       tx,
    input logic       e
  );
    chk({tag, ".dout"}, 32'(ia.dout), 32'(d));
    chk({tag, ".tx"}, 32'(ia.tx_valid), 32'(tx));
    chk({tag, ".err"}, 32'(ia.err), 32'(e));
  endtask

  task automatic chk_b(
    input string      tag,
    input logic [7:0] d,
    input logic       tx,
    input logic       e
  );
    chk({tag, ".dout"}, 32'(ib.dout), 32'(d));
    chk({tag, ".tx"}, 32'(ib.tx_valid), 32'(tx));
    chk({tag, ".err"}, 32'(ib.err), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0;
    ia.din = {2'b11, 8'h00}; ia.rx_valid = 1'b1;
    ib.din = {2'b11, 8'h00}; ib.rx_valid = 1'b1;
    @(posedge clk); #1;
    chk_a("rst0_a", 8'h00, 1'b0, 1'b0);
    chk_b("rst0_b", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_a("rst1_a", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle();
    chk_a("post_rst", 8'h00, 1'b0, 1'b0);

    step(0, 2'b00, 8'h10); chk_a("b_wa", 8'h00, 0, 0);
    step(0, 2'b01, 8'hA5); chk_a("b_wd", 8'h00, 0, 0);
    step(0, 2'b10, 8'h10); chk_a("b_ra", 8'h00, 0, 0);
    step(0, 2'b11, 8'h00); chk_a("b_rd", 8'hA5, 1, 0);
    idle();                chk_a("b_hold", 8'hA5, 0, 0);
    idle();                chk_a("b_noval", 8'hA5, 0, 0);

    step(0, 2'b00, 8'h10);
    step(0, 2'b10, 8'h10);
    step(0, 2'b01, 8'h3C); chk_a("wr_rd_w", 8'hA5, 0, 0);
    step(0, 2'b11, 8'h00); chk_a("wr_rd_r", 8'h3C, 1, 0);

    step(1, 2'b00, 8'hC7);
    step(1, 2'b01, 8'h77); chk_b("in_w", 8'h00, 0, 0);
    step(1, 2'b10, 8'hC7);
    step(1, 2'b11, 8'h00); chk_b("in_r", 8'h77, 1, 0);
    step(1, 2'b00, 8'hC8); chk_b("oob_wa", 8'h77, 0, 0);
    step(1, 2'b01, 8'h55); chk_b("oob_w", 8'h77, 0, 1);
    idle();                chk_b("oob_w1", 8'h77, 0, 0);
    step(1, 2'b10, 8'hC8);
    step(1, 2'b11, 8'h00); chk_b("oob_r", 8'h00, 1, 1);
    idle();                chk_b("oob_r1", 8'h00, 0, 0);
    step(1, 2'b10, 8'hC7);
    step(1, 2'b11, 8'h00); chk_b("in_r2", 8'h77, 1, 0);

    step(0, 2'b00, 8'hFF); step(0, 2'b01, 8'hEE);
    step(0, 2'b00, 8'h00); step(0, 2'b01, 8'hDD);
    step(0, 2'b00, 8'hFE);
    step(0, 2'b01, 8'h11);
    step(0, 2'b01, 8'h22);
    step(0, 2'b01, 8'h33);
    step(0, 2'b10, 8'hFE);
    step(0, 2'b11, 8'h00);
    chk_a("ai_r0", AI ? 8'h11 : 8'h33, 1, 0);
    step(0, 2'b11, 8'h00);
    chk_a("ai_r1", AI ? 8'h22 : 8'h33, 1, 0);
    step(0, 2'b11, 8'h00);
    chk_a("ai_r2", 8'h33, 1, 0);
    idle();
    chk_a("ai_end", 8'h33, 0, 0);
    step(0, 2'b10, 8'hFF);
    step(0, 2'b11, 8'h00);
    chk_a("ai_ff", AI ? 8'h22 : 8'hEE, 1, 0);
    step(0, 2'b11, 8'h00);
    chk_a("ai_00", AI ? 8'h33 : 8'hEE, 1, 0);

    rst_n = 1'b0;
    step(0, 2'b01, 8'h99);
    chk_a("mrst_w", 8'h00, 0, 0);
    step(0, 2'b11, 8'h00);
    chk_a("mrst_r", 8'h00, 0, 0);
    rst_n = 1'b1;
    step(0, 2'b11, 8'h00);
    chk_a("mrst_after", AI ? 8'h33 : 8'hDD, 1, 0);
    idle();
    chk_a("mrst_idle", AI ? 8'h33 : 8'hDD, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Parametrised single-port RAM behind the SPI slave front end. Decodes the 2-bit command prefix of each received word into write-address, write-data, read-address and read-data operations. Generalises the fixed 8-bit/256-word RAM with configurable data width, address width and depth, out-of-range detection and optional address auto-increment for burst transfers. Sits between the SPI slave shift logic (`din`/`rx_valid`) and the SPI transmit path (`dout`/`tx_valid`).

## Interface
- `DATA_WIDTH`, default 8: width of a memory word and of the command payload.
- `ADDR_SIZE`, default 8: width of the address pointers. Must be ≤ `DATA_WIDTH`; the address is taken from payload bits `[ADDR_SIZE-1:0]`.
- `MEM_DEPTH`, default 256: number of words. Must be ≤ 2^`ADDR_SIZE`.

Ports:
- `clk`, input, 1: clock. All logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `din`, input, `DATA_WIDTH+2`: received word. `din[DATA_WIDTH+1:DATA_WIDTH]` is the command; the lower bits are the payload.
- `rx_valid`, input, 1: `din` is valid this cycle; one command per asserted cycle.
- `dout`, output, `DATA_WIDTH`: read data.
- `tx_valid`, output, 1: `dout` is updated and valid; one-cycle pulse.
- `err`, output, 1: one-cycle pulse when an access targets an address ≥ `MEM_DEPTH`.

## Operation
- Commands are acted on only when `rx_valid`=1. When `rx_valid`=0, no state changes.
- Command `00`: `wr_addr` ← payload`[ADDR_SIZE-1:0]`.
- Command `01`: `mem[wr_addr]` ← payload`[DATA_WIDTH-1:0]`.
- Command `10`: `rd_addr` ← payload`[ADDR_SIZE-1:0]`.
- Command `11`: `dout` ← `mem[rd_addr]`, `tx_valid` ← 1. The payload is ignored.
- Out-of-range access (pointer ≥ `MEM_DEPTH`):
  - Loading such an address is legal; the pointer is stored.
  - A write (`01`) to it is dropped and `err` pulses.
  - A read (`11`) to it returns `dout`=0, `tx_valid` still pulses, and `err` pulses.
- Internal state: two address registers (`wr_addr`, `rd_addr`) and the memory array. No multi-cycle FSM; each command completes in one cycle.
- Memory contents are not reset.
- `dout` holds its last read value until the next `11` command or reset.

## Timing
- Reset values: `dout`=0, `tx_valid`=0, `err`=0, `wr_addr`=0, `rd_addr`=0.
- Reset is applied at the first rising edge with `rst_n`=0 and overrides any command in that cycle. A write presented in a reset cycle is not performed.
- Read latency is 1 cycle: command `11` sampled at edge N gives `dout`/`tx_valid` valid after edge N (visible in cycle N+1).
- `tx_valid` is 1 in the cycle after a valid `11` command and 0 after any other command or idle cycle, so back-to-back `11` commands hold `tx_valid` high continuously.
- `err` is registered and aligned with the write commit / `tx_valid` cycle.
- Write-then-read to the same address on consecutive cycles returns the new data (write commits at edge N, read samples at edge N+1).

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - After each `01` command, `wr_addr` increments by 1.
  - After each `11` command, `rd_addr` increments by 1.
  - Both pointers wrap from `MEM_DEPTH-1` to 0.
  - The increment also occurs on out-of-range accesses; the wrap compare is `ptr ≥ MEM_DEPTH-1` → 0.
- Not defined: pointers change only on `00`/`10` commands; repeated `01`/`11` commands reuse the same address.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `rx_valid`=1 and `din`=`11_xx` → `dout`=0, `tx_valid`=0, `err`=0 throughout.
- Basic: `00_0x10`, `01_0xA5`, `10_0x10`, `11_0x00` → `tx_valid`=1 for exactly one cycle with `dout`=0xA5. In every other cycle `tx_valid`=0.
- Out-of-range with `MEM_DEPTH`=200: `00_0xC8`, `01_0x55` → `err` pulse and no write. Then `10_0xC8`, `11` → `dout`=0, `tx_valid`=1, `err`=1.
- Auto-increment (macro on, `MEM_DEPTH`=256): `00_0xFE`, then `01` with 0x11, 0x22, 0x33 → writes land at 0xFE, 0xFF, 0x00. Then `10_0xFE` and three `11` commands → `dout` = 0x11, 0x22, 0x33 with `tx_valid` high for 3 consecutive cycles.
- Macro off: same sequence → all three writes land at 0xFE. Each read returns 0x33.
- Mid-operation reset: issue `11` together with `rst_n`=0 → `tx_valid` stays 0. After release, `rd_addr`=0 and memory contents are intact (reading a previously written address returns the old data).
